// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, instruction field
// positions, hazard controller state and register-usage decode helpers.
package pipe_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_BR0   = 4'b0100;
    localparam logic [3:0] OP_BR1   = 4'b0101;
    localparam logic [3:0] OP_BR2   = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1110;

    // Instruction field positions
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RS_MSB = 11;
    localparam int RS_LSB = 8;
    localparam int RT_MSB = 7;
    localparam int RT_LSB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hz_state_t;

    // Every op except halt reads rs.
    function automatic logic uses_rs(input logic [3:0] op);
        return (op != OP_HALT);
    endfunction

    // R-type, store and the three branch forms read rt.
    function automatic logic uses_rt(input logic [3:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE) ||
               (op == OP_BR0) || (op == OP_BR1) || (op == OP_BR2);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// There is no valid/ready handshake here: in_id_valid simply qualifies
// in_id_instr for the current cycle, and every control output is a
// same-cycle (combinational) response that the pipeline registers obey at
// the next rising edge.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    logic [15:0]      in_id_instr;
    logic             in_id_valid;
    logic             in_ex_mem_read;
    logic [3:0]       in_ex_rd;
    logic             in_ex_multi;
    logic             in_branch_taken;

    logic             out_pc_write;
    logic             out_ifid_write;
    logic             out_ifid_flush;
    logic             out_hz;
    logic             out_ex_hold;
    logic             out_mem_bubble;
    logic             out_busy;
    logic [CNT_W-1:0] out_stall_cnt;
    logic [CNT_W-1:0] out_flush_cnt;
    hz_state_t        dbg_state;

    // Pipeline side: drives the observations, consumes the controls.
    modport master (
        output in_id_instr, in_id_valid, in_ex_mem_read, in_ex_rd,
               in_ex_multi, in_branch_taken,
        input  out_pc_write, out_ifid_write, out_ifid_flush, out_hz,
               out_ex_hold, out_mem_bubble, out_busy, out_stall_cnt,
               out_flush_cnt, dbg_state
    );

    // Controller side.
    modport slave (
        input  in_id_instr, in_id_valid, in_ex_mem_read, in_ex_rd,
               in_ex_multi, in_branch_taken,
        output out_pc_write, out_ifid_write, out_ifid_flush, out_hz,
               out_ex_hold, out_mem_bubble, out_busy, out_stall_cnt,
               out_flush_cnt, dbg_state
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count register with synchronous clear and saturation at all-ones.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use bubble, taken-branch flush and a freeze of
// the front end while a multi-cycle mul/div op occupies EX. Controls are
// Mealy outputs of the IDLE/BUSY state plus the current-cycle inputs.
module hazard_stall_controller
    import pipe_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                     CLOCK,
    input  logic                     in_rst,
    hazard_stall_controller_if.slave bus
);

    // The entry cycle is the first EX cycle and the release cycle the last,
    // so the counter only has to cover the cycles strictly between them.
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

    hz_state_t  state, state_nx;
    logic [3:0] cyc_cnt, cyc_cnt_nx;

    logic [3:0] id_op, id_rs, id_rt;
    logic       load_use;

    logic pc_write, ifid_write, ifid_flush, hz, ex_hold, mem_bubble;
    logic flush_evt, stall_evt;

    assign id_op = bus.in_id_instr[OP_MSB:OP_LSB];
    assign id_rs = bus.in_id_instr[RS_MSB:RS_LSB];
    assign id_rt = bus.in_id_instr[RT_MSB:RT_LSB];

    // Register 0 is hard-wired, so a load into it never creates a hazard.
    assign load_use = bus.in_id_valid && bus.in_ex_mem_read &&
                      (bus.in_ex_rd != 4'd0) &&
                      ((uses_rs(id_op) && (id_rs == bus.in_ex_rd)) ||
                       (uses_rt(id_op) && (id_rt == bus.in_ex_rd)));

    // State and cycle counter; reset aborts any op in flight.
    always_ff @(posedge CLOCK) begin
        if (in_rst) begin
            state   <= ST_IDLE;
            cyc_cnt <= 4'd0;
        end else begin
            state   <= state_nx;
            cyc_cnt <= cyc_cnt_nx;
        end
    end

    // Next state and Mealy control outputs; branch outranks multi-cycle
    // entry, which outranks the load-use bubble.
    always_comb begin
        state_nx   = state;
        cyc_cnt_nx = cyc_cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        hz         = 1'b0;
        ex_hold    = 1'b0;
        mem_bubble = 1'b0;
        flush_evt  = 1'b0;

        if (in_rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            hz         = 1'b1;
            state_nx   = ST_IDLE;
            cyc_cnt_nx = 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_branch_taken) begin
                        ifid_flush = 1'b1;
                        hz         = 1'b1;
                        ifid_write = 1'b0;
                        flush_evt  = 1'b1;
                    end else if (bus.in_ex_multi) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        ex_hold    = 1'b1;
                        mem_bubble = 1'b1;
                        state_nx   = ST_BUSY;
                        cyc_cnt_nx = CNT_LOAD;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        hz         = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cyc_cnt != 4'd0) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        ex_hold    = 1'b1;
                        mem_bubble = 1'b1;
                        cyc_cnt_nx = cyc_cnt - 4'd1;
                    end else begin
                        // Release cycle: the op leaves EX; only the
                        // load-use check is live again.
                        state_nx = ST_IDLE;
                        if (load_use) begin
                            pc_write   = 1'b0;
                            ifid_write = 1'b0;
                            hz         = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx   = ST_IDLE;
                    cyc_cnt_nx = 4'd0;
                end
            endcase
        end
    end

    assign stall_evt = !in_rst && !pc_write;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLOCK),
        .clear (in_rst),
        .inc   (stall_evt),
        .count (bus.out_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLOCK),
        .clear (in_rst),
        .inc   (flush_evt),
        .count (bus.out_flush_cnt)
    );

    assign bus.out_pc_write   = pc_write;
    assign bus.out_ifid_write = ifid_write;
    assign bus.out_ifid_flush = ifid_flush;
    assign bus.out_hz         = hz;
    assign bus.out_ex_hold    = ex_hold;
    assign bus.out_mem_bubble = mem_bubble;
    assign bus.out_busy       = (state == ST_BUSY);
    assign bus.dbg_state      = state;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed steps from the test plan
// followed by random traffic, all checked against a cycle-level model.
module tb_hazard_stall_controller;

    localparam int MULDIV  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_controller #(
        .MULDIV_CYCLES (MULDIV),
        .CNT_W         (CNT_W)
    ) dut (
        .CLOCK  (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];

    // Model: m_occ = how many EX cycles the current multi-cycle op has
    // already spent (0 = no op in flight).
    int m_occ   = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_known = 1'b0;

    function automatic bit model_load_use();
        int instr, op, rs, rt, rd;
        bit rs_used, rt_used;
        instr   = int'(bus.in_id_instr);
        op      = instr / 4096;
        rs      = (instr / 256) % 16;
        rt      = (instr / 16) % 16;
        rd      = int'(bus.in_ex_rd);
        rs_used = (op != 14);
        rt_used = (op == 0) || (op == 12) || (op == 4) || (op == 5) || (op == 6);
        return bus.in_id_valid && bus.in_ex_mem_read && (rd != 0) &&
               ((rs_used && rs == rd) || (rt_used && rt == rd));
    endfunction

    task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (pc,ifw,flush,hz,hold,mbub,busy)", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs, input int exp);
        n_checks++;
        assert (obs === CNT_W'(exp)) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit r, input logic [15:0] instr, input bit valid,
                         input bit mem_read, input logic [3:0] ex_rd,
                         input bit multi, input bit branch);
        rst                 = r;
        bus.in_id_instr     = instr;
        bus.in_id_valid     = valid;
        bus.in_ex_mem_read  = mem_read;
        bus.in_ex_rd        = ex_rd;
        bus.in_ex_multi     = multi;
        bus.in_branch_taken = branch;
    endtask

    // One clock cycle: model the expected outputs, compare mid-cycle,
    // then advance the model across the rising edge.
    task automatic run_cycle(input string tag);
        bit pc, ifw, fl, hz, hold, mb, busy, lu, flush_ev;
        int nxt_occ;
        logic [6:0] e, o;
        #2;
        lu       = model_load_use();
        pc       = 1; ifw = 1; fl = 0; hz = 0; hold = 0; mb = 0;
        busy     = (m_occ != 0);
        nxt_occ  = m_occ;
        flush_ev = 0;
        if (rst) begin
            pc = 0; ifw = 0; fl = 1; hz = 1;
            nxt_occ = 0;
        end else if (m_occ == 0) begin
            if (bus.in_branch_taken) begin
                fl = 1; hz = 1; ifw = 0; flush_ev = 1;
            end else if (bus.in_ex_multi) begin
                pc = 0; ifw = 0; hold = 1; mb = 1;
                nxt_occ = 1;
            end else if (lu) begin
                pc = 0; ifw = 0; hz = 1;
            end
        end else if (m_occ < MULDIV - 1) begin
            pc = 0; ifw = 0; hold = 1; mb = 1;
            nxt_occ = m_occ + 1;
        end else begin
            nxt_occ = 0;
            if (lu) begin
                pc = 0; ifw = 0; hz = 1;
            end
        end
        e = {pc, ifw, fl, hz, hold, mb, busy};
        exp_q.push_back(e);
        o = {bus.out_pc_write, bus.out_ifid_write, bus.out_ifid_flush, bus.out_hz,
             bus.out_ex_hold, bus.out_mem_bubble, bus.out_busy};
        e = exp_q.pop_front();
        if (m_known) begin
            check_vec(tag, o, e);
            check_cnt({tag, "_stall_cnt"}, bus.out_stall_cnt, m_stall);
            check_cnt({tag, "_flush_cnt"}, bus.out_flush_cnt, m_flush);
        end else begin
            // State is still uninitialised before the first reset edge;
            // only the reset-forced controls are defined.
            check_vec(tag, {o[6:1], 1'b0}, {e[6:1], 1'b0});
        end
        @(posedge clk);
        if (rst) begin
            m_stall = 0;
            m_flush = 0;
            m_known = 1'b1;
        end else begin
            if (!pc && m_stall < CNT_MAX) m_stall++;
            if (flush_ev && m_flush < CNT_MAX) m_flush++;
        end
        m_occ = nxt_occ;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ops[8];
        logic [15:0] instr;
        ops = '{0, 4, 5, 6, 8, 12, 14, 3};
        drive(1, 16'h0000, 0, 0, 4'd0, 1, 0);
        @(negedge clk);

        // Reset held two cycles with a multi-cycle request pending
        run_cycle("reset0");
        run_cycle("reset1");
        drive(0, 16'h0000, 0, 0, 4'd0, 0, 0);
        run_cycle("idle_after_reset");
        check_cnt("post_reset_stall", bus.out_stall_cnt, 0);

        // Load-use on rs
        drive(0, 16'h0340, 1, 1, 4'd3, 0, 0);
        run_cycle("load_use_rs");
        drive(0, 16'h0000, 0, 0, 4'd0, 0, 0);
        run_cycle("after_load_use");
        check_cnt("load_use_stall_one", bus.out_stall_cnt, 1);

        // Variants that must not stall
        drive(0, 16'h0340, 1, 1, 4'd0, 0, 0);
        run_cycle("ex_rd_zero");
        drive(0, 16'hE300, 1, 1, 4'd3, 0, 0);
        run_cycle("halt_no_rs");
        drive(0, 16'h8130, 1, 1, 4'd3, 0, 0);
        run_cycle("load_rt_unused");
        drive(0, 16'h0340, 0, 1, 4'd3, 0, 0);
        run_cycle("id_not_valid");
        // rt hazard on R-type
        drive(0, 16'h0130, 1, 1, 4'd3, 0, 0);
        run_cycle("load_use_rt");

        // Branch beats load-use
        drive(0, 16'h0340, 1, 1, 4'd3, 0, 1);
        run_cycle("branch_over_load_use");
        drive(0, 16'h0000, 0, 0, 4'd0, 0, 0);
        run_cycle("after_branch");
        check_cnt("branch_flush_one", bus.out_flush_cnt, 1);

        // Multi-cycle op from a clean reset; request stays high through release
        drive(1, 16'h0000, 0, 0, 4'd0, 0, 0);
        run_cycle("reset_before_multi");
        drive(0, 16'h0000, 0, 0, 4'd0, 1, 0);
        for (int i = 0; i < MULDIV; i++) run_cycle("multi_op");
        drive(0, 16'h0000, 0, 0, 4'd0, 0, 1);
        run_cycle("branch_after_release");
        drive(0, 16'h0000, 0, 0, 4'd0, 1, 0);
        for (int i = 0; i < MULDIV; i++) run_cycle("multi_reentry");
        drive(0, 16'h0000, 0, 0, 4'd0, 0, 0);
        run_cycle("idle_after_multi");
        check_cnt("multi_stall_six", bus.out_stall_cnt, 6);

        // Branch during BUSY is ignored
        drive(0, 16'h0000, 0, 0, 4'd0, 1, 0);
        run_cycle("multi_entry_b");
        drive(0, 16'h0340, 1, 1, 4'd3, 0, 1);
        for (int i = 1; i < MULDIV; i++) run_cycle("busy_ignores_branch");

        // Reset aborts a busy op
        drive(0, 16'h0000, 0, 0, 4'd0, 1, 0);
        run_cycle("multi_entry_r");
        drive(1, 16'h0000, 0, 0, 4'd0, 0, 0);
        run_cycle("reset_in_busy");
        drive(0, 16'h0000, 0, 0, 4'd0, 0, 0);
        run_cycle("idle_after_abort");
        check_cnt("abort_stall_zero", bus.out_stall_cnt, 0);

        // Saturation of the stall counter
        drive(0, 16'h0340, 1, 1, 4'd3, 0, 0);
        for (int i = 0; i < 20; i++) run_cycle("saturate");
        check_cnt("stall_saturated", bus.out_stall_cnt, CNT_MAX);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            instr = {4'(ops[$urandom_range(0, 7)]), 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            drive(($urandom_range(0, 39) == 0), instr, ($urandom_range(0, 4) != 0),
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            run_cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
